// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the cores' load/store ports, the round-robin arbiter and the shared data RAM.
// The slave modport is the arbiter's view; the master modport is the view of the cores plus the RAM.
interface mem_bus_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        ack;
  logic [DATA_W-1:0]           rdata;
  logic                        busy;
  logic [IDW-1:0]              grant_id;
  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output ack, rdata, busy, grant_id, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  ack, rdata, busy, grant_id, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serialising NUM_PORTS core load/store requests onto one synchronous RAM.
// Each access takes IDLE -> ACCESS -> RESP -> DONE; ack pulses for one cycle in DONE.
module mem_bus_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [IDW-1:0]       r_ptr;
  logic [IDW-1:0]       r_grantId;
  logic [IDW-1:0]       w_winner;
  logic [IDW-1:0]       w_ptrNext;
  logic                 w_anyReq;
  logic [NUM_PORTS-1:0] r_ack;
  logic [DATA_W-1:0]    r_rdata;
  logic                 w_memEn;
  logic                 w_memWe;
  logic [ADDR_W-1:0]    w_portAddr  [NUM_PORTS];
  logic [DATA_W-1:0]    w_portWdata [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ports
    assign w_portAddr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign w_portWdata[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  // Scan downward so the last hit is the first requester at or after r_ptr.
  always_comb begin
    w_winner = r_ptr;
    w_anyReq = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (bus.req[(int'(r_ptr) + k) % NUM_PORTS]) begin
        w_winner = IDW'((int'(r_ptr) + k) % NUM_PORTS);
        w_anyReq = 1'b1;
      end
    end
  end

  assign w_ptrNext = (r_grantId == IDW'(NUM_PORTS - 1)) ? '0 : r_grantId + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_memEn     = 1'b0;
    w_memWe     = 1'b0;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = ACCESS;
      ACCESS: begin
        w_nextState = RESP;
        w_memEn     = !reset;
        w_memWe     = !reset && bus.req_we[r_grantId];
      end
      RESP:    w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Reads capture RAM data in RESP; writes leave rdata holding the last read value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_grantId <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_anyReq) r_grantId <= w_winner;
        RESP: begin
          if (!bus.req_we[r_grantId]) r_rdata <= bus.mem_rdata;
          r_ack <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_grantId;
          r_ptr <= w_ptrNext;
        end
        DONE: r_ack <= '0;
        default: ;
      endcase
    end
  end

  assign bus.ack       = r_ack;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.grant_id  = r_grantId;
  assign bus.mem_en    = w_memEn;
  assign bus.mem_we    = w_memWe;
  assign bus.mem_addr  = w_portAddr[r_grantId];
  assign bus.mem_wdata = w_portWdata[r_grantId];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a per-cycle vector table for single read/write,
// then hand-written sequences for round-robin order, fairness, reset mid-access and idling.
module tb_mem_bus_arbiter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic loadRam;
  logic [31:0] tbRam [256];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic        expBusy;
    logic        expEn;
    logic        expWe;
    logic [3:0]  expAck;
    logic [1:0]  expGrant;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [14];

  mem_bus_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model, read-before-write, data out one cycle after mem_en.
  always @(posedge clk) begin
    if (loadRam) begin
      for (int i = 0; i < 256; i++) tbRam[i] <= 32'h1000_0000 | 32'(i);
      tbRam[8'h10] <= 32'hDEADBEEF;
      tbRam[8'h30] <= 32'hC0FFEE00;
    end else if (bus.mem_en) begin
      if (bus.mem_we) tbRam[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= tbRam[bus.mem_addr[7:0]];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(logic [3:0] r, logic [3:0] w, logic b, logic e, logic mw,
                                 logic [3:0] a, logic [1:0] g, logic [31:0] ad,
                                 logic [31:0] wd, logic [31:0] rd);
    vec_t v;
    v.req = r; v.we = w; v.expBusy = b; v.expEn = e; v.expWe = mw;
    v.expAck = a; v.expGrant = g; v.expAddr = ad; v.expWdata = wd; v.expRdata = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w);
    bus.req    = r;
    bus.req_we = w;
  endtask

  task automatic setPort(input int p, input logic [31:0] a, input logic [31:0] d);
    bus.req_addr[p*32 +: 32]  = a;
    bus.req_wdata[p*32 +: 32] = d;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " busy"},   32'(bus.busy),     32'd0);
    checkOutput({tag, " ack"},    32'(bus.ack),      32'd0);
    checkOutput({tag, " mem_en"}, 32'(bus.mem_en),   32'd0);
    checkOutput({tag, " mem_we"}, 32'(bus.mem_we),   32'd0);
    checkOutput({tag, " grant"},  32'(bus.grant_id), 32'd0);
    checkOutput({tag, " rdata"},  bus.rdata,         32'd0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkReset(tag);
  endtask

  logic [31:0] rrData [4];
  logic [3:0]  reqMask;
  logic [3:0]  reraise;
  int          served;
  int          ackId;
  int          expOrder [4];

  initial begin
    reset   = 1'b1;
    loadRam = 1'b1;
    applyStimulus(4'b0000, 4'b0000);
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    setPort(0, 32'h30, 32'hA0A0A0A0);
    setPort(1, 32'h20, 32'h12345678);
    setPort(2, 32'h10, 32'h00000000);
    setPort(3, 32'h20, 32'h33333333);
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    loadRam = 1'b0;
    #1;
    checkReset("init");

    // Port 2 reads 0x10, port 1 writes 0x20, port 3 reads 0x20 back.
    vecs[0]  = mkVec(4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0,     0,            32'h0);
    vecs[1]  = mkVec(4'b0100, 4'b0000, 1, 1, 0, 4'b0000, 2'd2, 32'h10, 0,           32'h0);
    vecs[2]  = mkVec(4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 2'd2, 0,     0,            32'h0);
    vecs[3]  = mkVec(4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 2'd2, 0,     0,            32'hDEADBEEF);
    vecs[4]  = mkVec(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 2'd2, 0,     0,            32'hDEADBEEF);
    vecs[5]  = mkVec(4'b0010, 4'b0010, 0, 0, 0, 4'b0000, 2'd2, 0,     0,            32'hDEADBEEF);
    vecs[6]  = mkVec(4'b0010, 4'b0010, 1, 1, 1, 4'b0000, 2'd1, 32'h20, 32'h12345678, 32'hDEADBEEF);
    vecs[7]  = mkVec(4'b0010, 4'b0010, 1, 0, 0, 4'b0000, 2'd1, 0,     0,            32'hDEADBEEF);
    vecs[8]  = mkVec(4'b0010, 4'b0010, 1, 0, 0, 4'b0010, 2'd1, 0,     0,            32'hDEADBEEF);
    vecs[9]  = mkVec(4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 2'd1, 0,     0,            32'hDEADBEEF);
    vecs[10] = mkVec(4'b1000, 4'b0000, 1, 1, 0, 4'b0000, 2'd3, 32'h20, 0,           32'hDEADBEEF);
    vecs[11] = mkVec(4'b1000, 4'b0000, 1, 0, 0, 4'b0000, 2'd3, 0,     0,            32'hDEADBEEF);
    vecs[12] = mkVec(4'b1000, 4'b0000, 1, 0, 0, 4'b1000, 2'd3, 0,     0,            32'h12345678);
    vecs[13] = mkVec(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 2'd3, 0,     0,            32'h12345678);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].req, vecs[i].we);
      #1;
      checkOutput($sformatf("row%0d busy", i),   32'(bus.busy),     32'(vecs[i].expBusy));
      checkOutput($sformatf("row%0d mem_en", i), 32'(bus.mem_en),   32'(vecs[i].expEn));
      checkOutput($sformatf("row%0d mem_we", i), 32'(bus.mem_we),   32'(vecs[i].expWe));
      checkOutput($sformatf("row%0d ack", i),    32'(bus.ack),      32'(vecs[i].expAck));
      checkOutput($sformatf("row%0d grant", i),  32'(bus.grant_id), 32'(vecs[i].expGrant));
      checkOutput($sformatf("row%0d rdata", i),  bus.rdata,         vecs[i].expRdata);
      if (vecs[i].expEn)
        checkOutput($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].expAddr);
      if (vecs[i].expWe)
        checkOutput($sformatf("row%0d mem_wdata", i), bus.mem_wdata, vecs[i].expWdata);
      @(negedge clk);
    end

    // All four ports request together: acks on cycles 4, 8, 12, 16 for ports 0..3.
    rrData[0] = 32'hC0FFEE00;
    rrData[1] = 32'h12345678;
    rrData[2] = 32'hDEADBEEF;
    rrData[3] = 32'h12345678;
    doReset("rr reset");
    reqMask = 4'b1111;
    applyStimulus(reqMask, 4'b0000);
    for (int c = 1; c <= 20; c++) begin
      logic [3:0] expAck;
      #1;
      expAck = ((c % 4 == 0) && (c <= 16)) ? (4'b0001 << (c / 4 - 1)) : 4'b0000;
      checkOutput($sformatf("rr cycle%0d ack", c), 32'(bus.ack), 32'(expAck));
      if (expAck != 4'b0000)
        checkOutput($sformatf("rr cycle%0d rdata", c), bus.rdata, rrData[c / 4 - 1]);
      reqMask = reqMask & ~bus.ack;
      applyStimulus(reqMask, 4'b0000);
      @(negedge clk);
    end

    // Ports 0 and 3 keep requesting; grants must alternate.
    expOrder[0] = 0; expOrder[1] = 3; expOrder[2] = 0; expOrder[3] = 3;
    doReset("fair reset");
    reqMask = 4'b1001;
    reraise = 4'b0000;
    served  = 0;
    applyStimulus(reqMask, 4'b0000);
    for (int c = 0; c < 60 && served < 4; c++) begin
      #1;
      if (bus.ack != 4'b0000) begin
        case (bus.ack)
          4'b0001: ackId = 0;
          4'b1000: ackId = 3;
          default: ackId = 15;
        endcase
        checkOutput($sformatf("fair grant%0d", served), 32'(ackId), 32'(expOrder[served]));
        served++;
        reqMask = reqMask & ~bus.ack;
        reraise = bus.ack;
      end else if (reraise != 4'b0000) begin
        reqMask = reqMask | reraise;
        reraise = 4'b0000;
      end
      applyStimulus(reqMask, 4'b0000);
      @(negedge clk);
    end
    checkOutput("fair served", 32'(served), 32'd4);

    // Move ptr to 2 with a port-1 read, then reset in the ACCESS cycle of a port-1 write.
    doReset("rst reset");
    applyStimulus(4'b0010, 4'b0000);
    repeat (4) @(negedge clk);
    setPort(1, 32'h40, 32'h55555555);
    applyStimulus(4'b0010, 4'b0010);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst access mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("rst access mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    #1;
    checkOutput("rst after busy", 32'(bus.busy), 32'd0);
    checkOutput("rst after ack",  32'(bus.ack),  32'd0);
    @(negedge clk);
    #1;
    checkOutput("rst later ack", 32'(bus.ack), 32'd0);
    checkOutput("rst ram 0x40",  tbRam[8'h40], 32'h10000040);

    // Ports 0 and 2 together: port 0 must win, proving ptr returned to 0.
    applyStimulus(4'b0101, 4'b0000);
    @(negedge clk);
    #1;
    checkOutput("ptr grant", 32'(bus.grant_id), 32'd0);
    checkOutput("ptr mem_addr", bus.mem_addr, 32'h30);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("ptr ack0", 32'(bus.ack), 32'b0001);
    checkOutput("ptr rdata0", bus.rdata, 32'hC0FFEE00);
    applyStimulus(4'b0100, 4'b0000);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("ptr grant2", 32'(bus.grant_id), 32'd2);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("ptr ack2", 32'(bus.ack), 32'b0100);
    checkOutput("ptr rdata2", bus.rdata, 32'hDEADBEEF);
    applyStimulus(4'b0000, 4'b0000);

    // Ten idle cycles: nothing moves.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("idle%0d mem_en", c), 32'(bus.mem_en),   32'd0);
      checkOutput($sformatf("idle%0d ack", c),    32'(bus.ack),      32'd0);
      checkOutput($sformatf("idle%0d busy", c),   32'(bus.busy),     32'd0);
      checkOutput($sformatf("idle%0d grant", c),  32'(bus.grant_id), 32'd2);
      checkOutput($sformatf("idle%0d rdata", c),  bus.rdata,         32'hDEADBEEF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Round-robin arbiter that shares one single-ported synchronous data memory between `NUM_PORTS` RV32E cores in the multiprocessor. It sits between the cores' load/store interfaces and the shared data RAM. Each core raises a request with address, write enable and write data. The arbiter serializes the accesses, drives the RAM, and returns read data with a one-cycle acknowledge. Cores stall their EXECUTE state until they see `ack`.

## Interface
- `NUM_PORTS`, 4: number of requesters (2..8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `IDW`, derived: `ceil(log2(NUM_PORTS))`, minimum 1.

One clock; reset is synchronous and active-high.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_PORTS  request per port.
- `req_we`  in  NUM_PORTS  1 = write, 0 = read.
- `req_addr`  in  NUM_PORTS*ADDR_W  port i occupies `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  NUM_PORTS*DATA_W  port i occupies `[i*DATA_W +: DATA_W]`.
- `ack`  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- `rdata`  out  DATA_W  registered read data, shared by all ports; valid while `ack` is high.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  IDW  index of the port currently being served.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data; valid in the cycle after the `mem_en` cycle.

## Operation
- FSM states: IDLE → ACCESS → RESP → DONE → IDLE. There are no other transitions except reset.
- **IDLE**
  - If any `req` bit is high, pick the first set bit at or after `ptr`, searching upward modulo NUM_PORTS.
  - Register the winner into `grant_id` and go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - `mem_en=1`; `mem_we`, `mem_addr`, `mem_wdata` are taken combinationally from port `grant_id`.
  - Go to RESP.
- **RESP**
  - `rdata <= mem_rdata` for reads; `rdata` holds its old value for writes.
  - `ack[grant_id] <= 1`; `ptr <= (grant_id+1) mod NUM_PORTS`.
  - Go to DONE.
- **DONE**
  - `ack` is high for this cycle only; `req` is ignored.
  - Clear `ack` and go to IDLE.
- **Requester rules**
  - Hold `req`, `req_we`, `req_addr` and `req_wdata` stable from assertion until `ack` is sampled high.
  - Drop `req` at the edge that samples `ack`.
  - A request raised and dropped before it is granted is legal and is lost; the arbiter issues no access for it.
- **Output gating**
  - `mem_en` = (state==ACCESS) && !reset.
  - `mem_we` = `mem_en` && `req_we[grant_id]`.
  - `mem_addr` and `mem_wdata` are don't-care when `mem_en` is low.
- **Fairness:** the port just served has the lowest priority on the next arbitration. Any waiting port is served within NUM_PORTS transactions.
- **Ports and data**
  - A grant to an out-of-range index is impossible.
  - No width conversion is done; data passes through unchanged.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `grant_id`=0, `ack`=0, `rdata`=0, `busy`=0, `mem_en`=0, `mem_we`=0.
- **Latency:** `req` seen in IDLE at edge E0 → ACCESS during cycle E0..E1 → RESP → `ack` high during cycle E2..E3.
  - The requester observes `ack` at E3.
  - Minimum of 4 cycles per transaction; at most one transaction in flight.
- **Back-to-back:** a second port that is already requesting is granted at the IDLE edge right after DONE. Peak throughput is 1 access per 4 cycles.
- **Reset during ACCESS:** `mem_en` is forced low that same cycle, so no RAM write occurs. The next state is IDLE and no `ack` is issued.
- **Reset during RESP:** `ack` and `rdata` stay at 0.
- **Reset during DONE:** `ack` drops at the reset edge. The requester must treat a reset as cancelling any in-flight access.
- **Simultaneous requests:** resolved in a single IDLE cycle; there are no combinational paths from `req` to `ack`.

## Test plan
- **Single read:** after reset, port 2 reads 0x10 while the RAM holds 0xDEADBEEF at 0x10.
  - `mem_en`=1 with `mem_addr`=0x10 in cycle 2.
  - `ack`=4'b0100 and `rdata`=0xDEADBEEF in cycle 4.
- **Single write:** port 1 writes 0x1234_5678 to 0x20.
  - One cycle with `mem_en`=1, `mem_we`=1, `mem_addr`=0x20, `mem_wdata`=0x12345678.
  - `ack`=4'b0010.
  - A following read of 0x20 by port 3 returns 0x12345678.
- **Round-robin order:** all 4 ports request together after reset. `ack` pulses for ports 0,1,2,3, in that order, on cycles 4, 8, 12 and 16.
- **Fairness under load:** ports 0 and 3 request continuously, re-raising `req` the cycle after each ack.
  - Grants alternate 0,3,0,3.
  - Port 0 is never served twice in a row.
- **Reset during ACCESS:** reset is asserted during a write's ACCESS cycle.
  - `mem_we` never goes high; no `ack`.
  - `busy`=0 on the next cycle and `ptr`=0.
- **Idle behaviour:** `req`=0 for 10 cycles → `mem_en`, `ack` and `busy` stay 0. `grant_id` and `rdata` are unchanged.
